// File: rtl/peripheral_msi_byte_split_wb.sv
// peripheral_msi_byte_split_wb
//
// Sequential Wishbone bridge from a 32-bit master to an 8-bit slave. A master
// access with several active byte selects becomes consecutive single-byte
// slave accesses. The bridge walks the lanes in big-endian order: sel[3] maps
// to byte offset 0 and data [31:24]. Read bytes are gathered into one 32-bit
// word, and the master sees a single termination.
//
// Optional feature: define PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN to add a
// per-beat watchdog. A beat left unterminated for TIMEOUT cycles is abandoned
// and the master receives an error. Without the macro, the bridge waits
// indefinitely for the slave.
//
// Ports
//   wb_clk_i, wb_rst_ni           clock (rising edge) / synchronous active-low reset
//   wbm_adr_i/dat_i/sel_i/we_i    master request (adr[1:0] ignored)
//   wbm_cyc_i, wbm_stb_i          master cycle / strobe
//   wbm_cti_i, wbm_bte_i          accepted, ignored
//   wbm_dat_o                     assembled read data, valid with a termination only
//   wbm_ack_o/err_o/rty_o         master termination, one-cycle pulses
//   wbs_adr_o, wbs_dat_o          slave byte address / write byte
//   wbs_we_o, wbs_cyc_o, wbs_stb_o slave control
//   wbs_cti_o, wbs_bte_o          constant classic-cycle encodings
//   wbs_dat_i                     slave read byte
//   wbs_ack_i/err_i/rty_i         slave termination
module peripheral_msi_byte_split_wb #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic [31:0]   wbm_dat_i,
  input  logic [3:0]    wbm_sel_i,
  input  logic          wbm_we_i,
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  input  logic [2:0]    wbm_cti_i,
  input  logic [1:0]    wbm_bte_i,
  output logic [31:0]   wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_err_o,
  output logic          wbm_rty_o,
  output logic [AW-1:0] wbs_adr_o,
  output logic [7:0]    wbs_dat_o,
  output logic          wbs_we_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [2:0]    wbs_cti_o,
  output logic [1:0]    wbs_bte_o,
  input  logic [7:0]    wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  input  logic          wbs_rty_i
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR, S_RTY} state_t;

  state_t          state_q, state_d;
  logic [AW-3:0]   adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rbuf_q, rbuf_d;
  logic [3:0]      pend_q, pend_d;
  logic            we_q, we_d;
  logic [1:0]      cur_off, nxt_off;

  logic [31:0]     wbm_dat_q, wbm_dat_d;
  logic            wbm_ack_q, wbm_ack_d;
  logic            wbm_err_q, wbm_err_d;
  logic            wbm_rty_q, wbm_rty_d;
  logic [AW-1:0]   wbs_adr_q, wbs_adr_d;
  logic [7:0]      wbs_dat_q, wbs_dat_d;
  logic            wbs_we_q, wbs_we_d;
  logic            wbs_cyc_q, wbs_cyc_d;
  logic            wbs_stb_q, wbs_stb_d;

`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc = tmo_q + TW'(1);
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
`endif

  logic unused_ok;
  assign unused_ok = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

  // Offset of the highest-priority pending lane (sel[3] is served first).
  function automatic logic [1:0] first_off(input logic [3:0] m);
    if (m[3])      return 2'd0;
    else if (m[2]) return 2'd1;
    else if (m[1]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Byte for a given offset; offset 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] o);
    return d[{~o, 3'b000} +: 8];
  endfunction

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rbuf_d    = rbuf_q;
    pend_d    = pend_q;
    we_d      = we_q;
    wbm_ack_d = 1'b0;
    wbm_err_d = 1'b0;
    wbm_rty_d = 1'b0;
    wbm_dat_d = '0;
`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
    tmo_d     = '0;
`endif
    cur_off   = first_off(pend_q);

    unique case (state_q)
      S_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d  = wbm_adr_i[AW-1:2];
          dat_d  = wbm_dat_i;
          pend_d = wbm_sel_i;
          we_d   = wbm_we_i;
          rbuf_d = '0;
          if (wbm_sel_i != 4'b0000) begin
            state_d = S_ACCESS;
          end else begin
            // Nothing to transfer: acknowledge straight away with zero data.
            state_d   = S_DONE;
            wbm_ack_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (!wbm_cyc_i) begin
          // Master abort: drop the slave cycle silently.
          state_d = S_IDLE;
          pend_d  = '0;
        end else if (wbs_err_i) begin
          state_d   = S_ERR;
          wbm_err_d = 1'b1;
          pend_d    = '0;
        end else if (wbs_rty_i) begin
          state_d   = S_RTY;
          wbm_rty_d = 1'b1;
          pend_d    = '0;
        end else if (wbs_ack_i) begin
          if (!we_q) rbuf_d[{~cur_off, 3'b000} +: 8] = wbs_dat_i;
          pend_d = pend_q & ~(4'b1000 >> cur_off);
          if (pend_d == 4'b0000) begin
            state_d   = S_DONE;
            wbm_ack_d = 1'b1;
            wbm_dat_d = rbuf_d;
          end
        end
`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
        else if (tmo_inc == TMO_LIM) begin
          state_d   = S_ERR;
          wbm_err_d = 1'b1;
          pend_d    = '0;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      S_DONE, S_ERR, S_RTY: state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase

    // Slave outputs follow the lane that will be pending after this edge, so
    // the next byte appears the cycle after an ack with stb held high.
    nxt_off   = first_off(pend_d);
    wbs_cyc_d = (state_d == S_ACCESS);
    wbs_stb_d = (state_d == S_ACCESS);
    wbs_we_d  = (state_d == S_ACCESS) && we_d;
    wbs_adr_d = (state_d == S_ACCESS) ? {adr_d, nxt_off} : '0;
    wbs_dat_d = (state_d == S_ACCESS) ? lane_byte(dat_d, nxt_off) : 8'h00;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      we_q      <= 1'b0;
      wbm_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_cyc_q <= 1'b0;
      wbs_stb_q <= 1'b0;
`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      we_q      <= we_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_ack_q <= wbm_ack_d;
      wbm_err_q <= wbm_err_d;
      wbm_rty_q <= wbm_rty_d;
      wbs_adr_q <= wbs_adr_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_we_q  <= wbs_we_d;
      wbs_cyc_q <= wbs_cyc_d;
      wbs_stb_q <= wbs_stb_d;
`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Request capture and read gather buffer; always rewritten before use.
  always_ff @(posedge wb_clk_i) begin
    adr_q  <= adr_d;
    dat_q  <= dat_d;
    rbuf_q <= rbuf_d;
  end

  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_rty_o = wbm_rty_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_cyc_o = wbs_cyc_q;
  assign wbs_stb_o = wbs_stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

endmodule

// File: tb/tb_peripheral_msi_byte_split_wb.sv
module tb_peripheral_msi_byte_split_wb;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o;
  logic [7:0]  wbs_dat_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [7:0]  s_dat;
  logic        s_ack, s_err, s_rty;

  peripheral_msi_byte_split_wb #(.AW(32), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),       .wb_rst_ni(rst_n),
    .wbm_adr_i(m_adr),     .wbm_dat_i(m_dat),     .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),      .wbm_cyc_i(m_cyc),     .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti),     .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),     .wbs_ack_i(s_ack),     .wbs_err_i(s_err),
    .wbs_rty_i(s_rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;

  // Slave model: byte memory, configurable wait states and fault injection.
  typedef struct packed {logic [31:0] adr; logic [7:0] dat; logic we;} beat_t;
  beat_t      beats[$];
  logic [7:0] mem [256];
  int         slv_wait = 0;
  int         slv_fault_beat = -1;
  int         slv_fault_kind = 0;   // 1 = err, 2 = rty
  bit         slv_mute = 1'b0;
  int         bcyc = 0;
  int         bidx = 0;

  initial begin
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 8'h00;
  end

  always @(posedge clk) begin
    #1;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 8'h00;
    if (!(wbs_cyc_o && wbs_stb_o)) begin
      bcyc = 0;
      bidx = 0;
    end else if (bcyc == slv_wait && !slv_mute) begin
      if (bidx == slv_fault_beat && slv_fault_kind == 1) s_err = 1'b1;
      else if (bidx == slv_fault_beat && slv_fault_kind == 2) s_rty = 1'b1;
      else begin
        s_ack = 1'b1;
        if (!wbs_we_o) s_dat = mem[wbs_adr_o[7:0]];
        beats.push_back('{adr: wbs_adr_o, dat: wbs_dat_o, we: wbs_we_o});
      end
      bcyc = 0;
      bidx++;
    end else begin
      bcyc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One master access; expectations come from the lane rules, not the DUT.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input int wt, input int fbeat, input int fkind,
                      output logic [31:0] obs_dat);
    logic [1:0]  offs[$];
    logic [31:0] exp_rd;
    logic [7:0]  idx;
    logic [2:0]  exp_kind;
    int n, nacked, lat, edges;
    bit got;
    for (int o = 0; o < 4; o++) if (sel[3-o]) offs.push_back(2'(o));
    n = offs.size();
    exp_rd = 32'h0;
    if (fkind != 0 && fbeat < n) begin
      nacked   = fbeat;
      exp_kind = (fkind == 1) ? 3'b010 : 3'b001;
      lat      = (fbeat + 1) * (wt + 1) + 1;
    end else begin
      nacked   = n;
      exp_kind = 3'b100;
      lat      = (n == 0) ? 1 : n * (wt + 1) + 1;
      if (!we) foreach (offs[i]) begin
        idx = {adr[7:2], offs[i]};
        exp_rd = exp_rd | (32'(mem[idx]) << (8 * (3 - int'(offs[i]))));
      end
    end
    slv_wait = wt; slv_fault_beat = fbeat; slv_fault_kind = fkind;
    beats.delete();
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
    m_cti = 3'($urandom); m_bte = 2'($urandom);
    edges = 0; got = 1'b0;
    while (!got && edges < 400) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) got = 1'b1;
    end
    obs_dat = wbm_dat_o;
    m_cyc = 1'b0; m_stb = 1'b0; m_sel = 4'h0; m_we = 1'b0;
    check("term_seen", 64'(got), 64'd1);
    check("term_kind", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'(exp_kind));
    check("latency", 64'(edges), 64'(lat));
    check("rdata", 64'(wbm_dat_o), 64'(exp_rd));
    check("slave_idle_at_term", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    check("beat_count", 64'(beats.size()), 64'(nacked));
    for (int i = 0; i < nacked && i < beats.size(); i++) begin
      check("beat_adr", 64'(beats[i].adr), 64'({adr[31:2], offs[i]}));
      check("beat_we", 64'(beats[i].we), 64'(we));
      if (we) check("beat_dat", 64'(beats[i].dat), 64'(dat[8 * (3 - int'(offs[i])) +: 8]));
    end
    @(posedge clk); @(negedge clk);
    check("single_pulse", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o}), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int hi, nterm;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    m_cti = '0; m_bte = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_master", 64'({wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
    check("reset_slave", 64'({wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
                              wbs_cti_o, wbs_bte_o}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("idle_no_cycle", 64'({wbs_cyc_o, wbm_ack_o}), 64'd0);

    // Four-byte write at 0x100, zero-wait slave.
    xfer(32'h100, 32'hA1B2C3D4, 4'b1111, 1'b1, 0, -1, 0, rd);

    // Sparse read at 0x200 returning 0x5A then 0x3C.
    mem[8'h01] = 8'h5A; mem[8'h03] = 8'h3C;
    xfer(32'h200, 32'h0, 4'b0101, 1'b0, 0, -1, 0, rd);
    check("read_0101_word", 64'(rd), 64'h005A003C);

    // No selects: immediate ack with zero data, no slave cycle.
    xfer(32'h300, 32'hFFFF_FFFF, 4'b0000, 1'b0, 0, -1, 0, rd);

    // Error on the first of two beats.
    xfer(32'h400, 32'h0, 4'b1100, 1'b0, 0, 0, 1, rd);

    // Retry on the second beat, and a read with two wait states per beat.
    xfer(32'h500, 32'h11223344, 4'b1011, 1'b1, 1, 1, 2, rd);
    xfer(32'h5C4, 32'h0, 4'b0111, 1'b0, 2, -1, 0, rd);

    // Reset during the second beat of a four-byte write.
    slv_wait = 0; slv_fault_beat = -1; slv_fault_kind = 0;
    m_adr = 32'h600; m_dat = 32'hDEADBEEF; m_sel = 4'hF; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("second_beat_adr", 64'(wbs_adr_o), 64'h601);
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_sel = 4'h0; m_we = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midreset_master", 64'({wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
    check("midreset_slave", 64'({wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_cyc_o, wbs_stb_o}), 64'd0);
    rst_n = 1'b1;
    xfer(32'h640, 32'h0, 4'b1001, 1'b0, 0, -1, 0, rd);

    // Slave that never answers.
    slv_mute = 1'b1; slv_fault_beat = -1; slv_fault_kind = 0;
    m_adr = 32'h700; m_sel = 4'b0010; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    hi = 0; nterm = 0;
`ifdef PERIPHERAL_MSI_BYTE_SPLIT_TIMEOUT_EN
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); @(negedge clk);
      if (wbs_stb_o) hi++;
      if (wbm_err_o) begin nterm++; m_cyc = 1'b0; m_stb = 1'b0; end
    end
    check("timeout_stb_cycles", 64'(hi), 64'd16);
    check("timeout_err_pulses", 64'(nterm), 64'd1);
    m_cyc = 1'b0; m_stb = 1'b0;
`else
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); @(negedge clk);
      if (wbs_stb_o) hi++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) nterm++;
    end
    check("stall_stb_cycles", 64'(hi), 64'd120);
    check("stall_no_term", 64'(nterm), 64'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_slave_drop", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    check("abort_no_term", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
`endif
    @(posedge clk); @(negedge clk);
    slv_mute = 1'b0;
    m_sel = 4'h0;
    xfer(32'h7F0, 32'h0, 4'b1111, 1'b0, 0, -1, 0, rd);

    // Randomized accesses against the lane model.
    for (int t = 0; t < 40; t++) begin
      int fk, fb;
      fk = ($urandom_range(7) == 0) ? 1 : (($urandom_range(7) == 0) ? 2 : 0);
      fb = (fk != 0) ? int'($urandom_range(3)) : -1;
      xfer($urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(2)), fb, fk, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
